// File: rtl/mem_port_arbiter.sv
// Two-client arbiter for the unified memory port: instruction fetch (IF) and load/store (DM).
// One transaction in flight; DM has priority, bounded by an IF anti-starvation counter.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                if_kill,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                o_busy,
  output logic                dbg_state_o,
  output logic [3:0]          dbg_starve_cnt_o
);

  // Handshake: a client holds req (and its fields) until it sees gnt in the same cycle;
  // gnt/mem_req are single-cycle pulses, and rvalid pulses exactly once per granted access
  // (suppressed for killed fetches). mem_rvalid is only honoured while a transaction is open.

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic       owner_dm_q, owner_dm_d;
  logic       killed_q, killed_d;
  logic [3:0] starve_q, starve_d;
  logic       if_win, dm_win, rsp;

  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (!rst && state_q == ST_IDLE) begin
      if_win = if_req && (!dm_req || starve_q >= STARVE_LIM);
      dm_win = dm_req && !if_win;
    end
  end

  assign rsp = !rst && (state_q == ST_WAIT) && mem_rvalid;

  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    killed_d   = killed_q;
    starve_d   = starve_q;
    case (state_q)
      ST_IDLE: begin
        if (if_win) begin
          state_d    = ST_WAIT;
          owner_dm_d = 1'b0;
          killed_d   = if_kill;
          starve_d   = 4'd0;
        end else if (dm_win) begin
          state_d    = ST_WAIT;
          owner_dm_d = 1'b1;
          killed_d   = 1'b0;
          if (if_req && starve_q != 4'hF) starve_d = starve_q + 4'd1;
        end
      end
      ST_WAIT: begin
        // A flush anywhere in a fetch's lifetime poisons its response.
        if (!owner_dm_q && if_kill) killed_d = 1'b1;
        if (mem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_dm_q <= 1'b0;
      killed_q   <= 1'b0;
      starve_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      killed_q   <= killed_d;
      starve_q   <= starve_d;
    end
  end

  assign if_gnt    = if_win;
  assign dm_gnt    = dm_win;
  assign mem_req   = if_win || dm_win;
  assign mem_we    = dm_win && dm_we;
  assign mem_addr  = dm_win ? dm_addr : (if_win ? if_addr : '0);
  assign mem_wdata = dm_win ? dm_wdata : '0;
  assign mem_wstrb = dm_win ? dm_wstrb : '0;

  assign dm_rvalid = rsp && owner_dm_q;
  assign if_rvalid = rsp && !owner_dm_q && !killed_q && !if_kill;
  assign if_rdata  = rst ? '0 : mem_rdata;
  assign dm_rdata  = rst ? '0 : mem_rdata;

  assign o_busy           = !rst && (state_q == ST_WAIT);
  assign dbg_state_o      = rst ? 1'b0 : state_q;
  assign dbg_starve_cnt_o = rst ? 4'd0 : starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model with a variable-latency memory.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 0, if_kill = 0, dm_req = 0, dm_we = 0, mem_rvalid = 0;
  logic [ADDR_W-1:0] if_addr = '0, dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0, mem_rdata = '0;
  logic [3:0] dm_wstrb = '0;
  logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, o_busy, dbg_state;
  logic [DATA_W-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0] mem_wstrb, dbg_starve;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_kill(if_kill),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .o_busy(o_busy), .dbg_state_o(dbg_state), .dbg_starve_cnt_o(dbg_starve)
  );

  // Drivers: every task starts and ends 1 time unit after a rising edge.
  task automatic clear_inputs();
    if_req = 0; if_kill = 0; dm_req = 0; dm_we = 0; mem_rvalid = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0; mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1; clear_inputs();
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; if_req = 1; dm_req = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    next_cycle();
    @(negedge clk);
    vectors++; if (if_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_if_gnt act=%b exp=0", if_gnt); end
    vectors++; if (dm_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_dm_gnt act=%b exp=0", dm_gnt); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req act=%b exp=0", mem_req); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy act=%b exp=0", o_busy); end
    vectors++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid act=%b%b exp=00", if_rvalid, dm_rvalid); end
    vectors++; if (if_rdata !== '0) begin miscompares++; $display("FAIL reset_rdata act=%h exp=0", if_rdata); end
    next_cycle();
    rst = 0; clear_inputs();
    @(negedge clk);
    vectors++; if (dbg_starve !== 4'd0 || dbg_state !== 1'b0) begin miscompares++; $display("FAIL reset_state act=%0d/%b exp=0/0", dbg_starve, dbg_state); end
    next_cycle();
  endtask

  task automatic test_if_only();
    do_reset();
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    vectors++; if (if_gnt !== 1'b1 || mem_req !== 1'b1) begin miscompares++; $display("FAIL ifonly_gnt act=%b%b exp=11", if_gnt, mem_req); end
    vectors++; if (mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin miscompares++; $display("FAIL ifonly_mem act=%h/%b/%h exp=100/0/0", mem_addr, mem_we, mem_wstrb); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL ifonly_busy0 act=%b exp=0", o_busy); end
    next_cycle();
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    vectors++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0050_0093) begin miscompares++; $display("FAIL ifonly_rsp act=%b/%h exp=1/00500093", if_rvalid, if_rdata); end
    vectors++; if (o_busy !== 1'b1 || if_gnt !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL ifonly_wait act=%b%b%b exp=100", o_busy, if_gnt, mem_req); end
    next_cycle();
    mem_rvalid = 0;
    @(negedge clk);
    vectors++; if (o_busy !== 1'b0 || if_rvalid !== 1'b0) begin miscompares++; $display("FAIL ifonly_done act=%b%b exp=00", o_busy, if_rvalid); end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req = 1; if_addr = 32'h108;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
    @(negedge clk);
    vectors++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin miscompares++; $display("FAIL simul_gnt act=if%b dm%b exp=if0 dm1", if_gnt, dm_gnt); end
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'hF) begin miscompares++; $display("FAIL simul_mem act=%b/%h/%h/%h exp=1/2000/deadbeef/f", mem_we, mem_addr, mem_wdata, mem_wstrb); end
    next_cycle();
    dm_req = 0; dm_we = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_0001;
    @(negedge clk);
    vectors++; if (dbg_starve !== 4'd1) begin miscompares++; $display("FAIL simul_starve1 act=%0d exp=1", dbg_starve); end
    vectors++; if (dm_rvalid !== 1'b1 || if_rvalid !== 1'b0 || dm_rdata !== 32'hA5A5_0001) begin miscompares++; $display("FAIL simul_ack act=%b%b/%h exp=10/a5a50001", dm_rvalid, if_rvalid, dm_rdata); end
    next_cycle();
    mem_rvalid = 0;
    @(negedge clk);
    vectors++; if (if_gnt !== 1'b1 || mem_addr !== 32'h108 || mem_we !== 1'b0) begin miscompares++; $display("FAIL simul_if_gnt act=%b/%h/%b exp=1/108/0", if_gnt, mem_addr, mem_we); end
    next_cycle();
    if_req = 0; mem_rvalid = 1;
    @(negedge clk);
    vectors++; if (dbg_starve !== 4'd0 || if_rvalid !== 1'b1) begin miscompares++; $display("FAIL simul_starve0 act=%0d/%b exp=0/1", dbg_starve, if_rvalid); end
    next_cycle();
    mem_rvalid = 0;
  endtask

  task automatic test_starvation();
    do_reset();
    if_req = 1; if_addr = 32'h300; dm_req = 1; dm_we = 0; dm_addr = 32'h4000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (dbg_starve !== 4'(i)) begin miscompares++; $display("FAIL starve_cnt[%0d] act=%0d exp=%0d", i, dbg_starve, i); end
      vectors++; if (if_gnt !== (i == 4) || dm_gnt !== (i != 4)) begin miscompares++; $display("FAIL starve_gnt[%0d] act=if%b dm%b exp=if%b", i, if_gnt, dm_gnt, i == 4); end
      next_cycle();
      mem_rvalid = 1;
      if (i == 4) if_req = 0;
      next_cycle();
      mem_rvalid = 0;
    end
    @(negedge clk);
    vectors++; if (dbg_starve !== 4'd0 || dm_gnt !== 1'b1) begin miscompares++; $display("FAIL starve_after act=%0d/%b exp=0/1", dbg_starve, dm_gnt); end
    next_cycle();
    dm_req = 0; mem_rvalid = 1;
    next_cycle();
    mem_rvalid = 0;
  endtask

  task automatic test_flush();
    do_reset();
    if_req = 1; if_addr = 32'h104;
    @(negedge clk);
    vectors++; if (if_gnt !== 1'b1 || mem_addr !== 32'h104) begin miscompares++; $display("FAIL flush_gnt act=%b/%h exp=1/104", if_gnt, mem_addr); end
    next_cycle();
    if_req = 0; if_kill = 1;
    next_cycle();
    if_kill = 0;
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    vectors++; if (if_rvalid !== 1'b0 || o_busy !== 1'b1) begin miscompares++; $display("FAIL flush_drop act=%b/%b exp=0/1", if_rvalid, o_busy); end
    next_cycle();
    mem_rvalid = 0; if_req = 1; if_addr = 32'h200;
    @(negedge clk);
    vectors++; if (if_gnt !== 1'b1 || mem_addr !== 32'h200) begin miscompares++; $display("FAIL flush_regnt act=%b/%h exp=1/200", if_gnt, mem_addr); end
    next_cycle();
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    vectors++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h13) begin miscompares++; $display("FAIL flush_next act=%b/%h exp=1/13", if_rvalid, if_rdata); end
    next_cycle();
    mem_rvalid = 0;
  endtask

  task automatic test_kill_on_response();
    do_reset();
    if_req = 1; if_addr = 32'h400;
    next_cycle();
    if_req = 0; mem_rvalid = 1; if_kill = 1;
    @(negedge clk);
    vectors++; if (if_rvalid !== 1'b0) begin miscompares++; $display("FAIL killrsp_rvalid act=%b exp=0", if_rvalid); end
    next_cycle();
    mem_rvalid = 0; if_kill = 0;
    @(negedge clk);
    vectors++; if (o_busy !== 1'b0 || dbg_state !== 1'b0) begin miscompares++; $display("FAIL killrsp_idle act=%b/%b exp=0/0", o_busy, dbg_state); end
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h5000;
    @(negedge clk);
    vectors++; if (dm_gnt !== 1'b1) begin miscompares++; $display("FAIL rstmid_gnt act=%b exp=1", dm_gnt); end
    next_cycle();
    dm_req = 0; rst = 1;
    next_cycle();
    rst = 0;
    @(negedge clk);
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy act=%b exp=0", o_busy); end
    next_cycle();
    mem_rvalid = 1; if_req = 1; if_addr = 32'h500;
    @(negedge clk);
    vectors++; if (dm_rvalid !== 1'b0 || if_gnt !== 1'b1) begin miscompares++; $display("FAIL rstmid_stale act=dmrv%b ifgnt%b exp=0/1", dm_rvalid, if_gnt); end
    next_cycle();
    if_req = 0; mem_rvalid = 1;
    @(negedge clk);
    vectors++; if (if_rvalid !== 1'b1 || dm_rvalid !== 1'b0) begin miscompares++; $display("FAIL rstmid_if act=%b/%b exp=1/0", if_rvalid, dm_rvalid); end
    next_cycle();
    mem_rvalid = 0;
  endtask

  // Reference model: one open transaction with owner and poison flag, plus a denial count.
  task automatic test_random();
    bit m_busy = 0, m_owner_dm = 0, m_killed = 0;
    int m_denials = 0;
    bit if_pend = 0, dm_pend = 0, mem_out = 0;
    int mem_cnt = 0;
    bit e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv;
    logic [ADDR_W-1:0] e_addr;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!if_pend) begin if_req = ($urandom_range(0, 1) == 1); if_addr = $urandom; if_pend = if_req; end
      if (!dm_pend) begin
        dm_req = ($urandom_range(0, 2) != 0); dm_we = $urandom_range(0, 1);
        dm_addr = $urandom; dm_wdata = $urandom; dm_wstrb = 4'($urandom_range(0, 15)); dm_pend = dm_req;
      end
      if_kill = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      if (mem_out) begin
        mem_cnt--;
        mem_rvalid = (mem_cnt == 0);
        if (mem_cnt == 0) mem_out = 0;
      end else begin
        mem_rvalid = !m_busy && ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      e_if_gnt = !m_busy && if_req && (!dm_req || m_denials >= STARVE_MAX);
      e_dm_gnt = !m_busy && dm_req && !e_if_gnt;
      e_if_rv  = m_busy && !m_owner_dm && mem_rvalid && !m_killed && !if_kill;
      e_dm_rv  = m_busy && m_owner_dm && mem_rvalid;
      e_addr   = e_dm_gnt ? dm_addr : if_addr;
      vectors++; if (if_gnt !== e_if_gnt || dm_gnt !== e_dm_gnt || mem_req !== (e_if_gnt || e_dm_gnt)) begin miscompares++; $display("FAIL rnd_gnt cyc=%0d act=if%b dm%b req%b exp=if%b dm%b", cyc, if_gnt, dm_gnt, mem_req, e_if_gnt, e_dm_gnt); end
      vectors++; if (if_rvalid !== e_if_rv || dm_rvalid !== e_dm_rv) begin miscompares++; $display("FAIL rnd_rvalid cyc=%0d act=if%b dm%b exp=if%b dm%b", cyc, if_rvalid, dm_rvalid, e_if_rv, e_dm_rv); end
      vectors++; if (o_busy !== m_busy || dm_rdata !== mem_rdata || if_rdata !== mem_rdata) begin miscompares++; $display("FAIL rnd_busy_data cyc=%0d act=%b/%h exp=%b/%h", cyc, o_busy, dm_rdata, m_busy, mem_rdata); end
      if (e_if_gnt || e_dm_gnt) begin
        vectors++; if (mem_addr !== e_addr || mem_we !== (e_dm_gnt && dm_we)) begin miscompares++; $display("FAIL rnd_addr cyc=%0d act=%h/%b exp=%h/%b", cyc, mem_addr, mem_we, e_addr, e_dm_gnt && dm_we); end
        if (e_dm_gnt) begin
          vectors++; if (mem_wdata !== dm_wdata || mem_wstrb !== dm_wstrb) begin miscompares++; $display("FAIL rnd_wdata cyc=%0d act=%h/%h exp=%h/%h", cyc, mem_wdata, mem_wstrb, dm_wdata, dm_wstrb); end
        end else begin
          vectors++; if (mem_wstrb !== 4'h0) begin miscompares++; $display("FAIL rnd_if_strb cyc=%0d act=%h exp=0", cyc, mem_wstrb); end
        end
      end
      if (m_busy) begin
        if (!m_owner_dm && if_kill) m_killed = 1;
        if (mem_rvalid) m_busy = 0;
      end else if (e_if_gnt) begin
        m_busy = 1; m_owner_dm = 0; m_killed = if_kill; m_denials = 0;
      end else if (e_dm_gnt) begin
        m_busy = 1; m_owner_dm = 1; m_killed = 0;
        if (if_req) m_denials = (m_denials + 1 > 15) ? 15 : m_denials + 1;
      end
      if (e_if_gnt || e_dm_gnt) begin mem_out = 1; mem_cnt = $urandom_range(1, 3); end
      if (e_if_gnt) if_pend = 0;
      if (e_dm_gnt) dm_pend = 0;
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_if_only();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_kill_on_response();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
